amiq_fifo_prog: RTL and testbench
=================================

// Module: amiq_fifo_prog
// PURPOSE
//  Synchronous single-clock FIFO, depth 2**P, with run-time programmable almost-full/almost-empty
//  thresholds, fill-level output, synchronous flush, sticky overflow/underflow errors and a
//  build-time selectable read mode (registered or first-word-fall-through). Sits between a producer
//  and a consumer in the amiq_fifo datapath; threshold/reset inputs driven by the FIFO control agent.
// PARAMETERS
//  DATA_W  8  data word width in bits
//  P       4  address width; DEPTH = 2**P entries; thresholds are P bits, level is P+1 bits
//  FWFT    0  0: registered read (data 1 cycle after pop); 1: first-word-fall-through
// PORTS
//  clk               in   1       clock, all state on rising edge
//  rst_n             in   1       asynchronous active-low reset
//  flush             in   1       synchronous clear of contents
//  wr_en             in   1       write request
//  wr_data           in   DATA_W  write data
//  rd_en             in   1       read/pop request
//  rd_data           out  DATA_W  read data
//  rd_valid          out  1       rd_data valid
//  full              out  1       level == DEPTH
//  empty             out  1       level == 0
//  alm_full_thresh   in   P       free-slot count at/below which alm_full asserts
//  alm_empty_thresh  in   P       fill count at/below which alm_empty asserts
//  alm_full          out  1       (DEPTH - level) <= alm_full_thresh
//  alm_empty         out  1       level <= alm_empty_thresh
//  level             out  P+1     current number of stored entries
//  overflow          out  1       sticky: write attempted while full
//  underflow         out  1       sticky: read attempted while empty
//  err_clr           in   1       clears overflow/underflow
// BEHAVIOUR
//  - Reset (rst_n=0, immediate): wr/rd pointers=0, level=0, empty=1, full=0, alm_empty=1,
//    alm_full=0, overflow=0, underflow=0, rd_valid=0, rd_data=0. Reset mid-operation discards data.
//  - Write accepted iff wr_en && !full; read accepted iff rd_en && !empty. Evaluated on current flags.
//  - Pointers are P bits and wrap DEPTH-1 -> 0; level tracks separately, range 0..DEPTH.
//  - Accepted wr+rd same cycle: level unchanged, order preserved. At full: write rejected, read
//    accepted, level-1, overflow set. At empty: read rejected, write accepted, underflow set.
//  - Rejected write: memory/pointers untouched, overflow<=1. Rejected read: underflow<=1, rd_valid=0.
//  - Sticky errors stay set until err_clr; err_clr with a new error in the same cycle -> error stays 1.
//  - flush (sync, priority over wr_en/rd_en): pointers/level to 0, flags as reset, rd_valid<=0;
//    concurrent wr/rd dropped without raising errors; overflow/underflow preserved.
//  - full/empty/alm_full/alm_empty/level registered, computed from next level, so all are coherent
//    in the same cycle. Threshold changes reflect in alm_* on the next clock edge.
//  - FWFT=0: accepted read -> rd_data = head word, rd_valid=1 one cycle later; rd_valid=0 the cycle
//    after a non-accepted read; rd_data holds last value otherwise.
//  - FWFT=1: rd_data = head word, rd_valid = !empty; a written word appears on rd_data the cycle
//    after its write when FIFO was empty; rd_en && rd_valid pops, next word visible next cycle.
//  - alm_full never asserts at level 0 (max thresh DEPTH-1); alm_empty always 1 at level 0.
// TESTING (P=4, DEPTH=16, DATA_W=8)
//  1 Write 5 words, drop rst_n mid-cycle -> level=0, empty=1, alm_empty=1 before next clk edge.
//  2 alm_full_thresh=3, write 0x00..0x10 -> alm_full=1 when level=13, full=1 at 16; 17th write
//    -> overflow=1, level=16, read-back order 0x00..0x0F intact.
//  3 At level 16 wr_en+rd_en -> level=15, overflow=1; at level 8 wr_en+rd_en for 20 cycles ->
//    level stays 8, data order preserved.
//  4 rd_en while empty -> underflow=1, rd_valid=0; err_clr pulse -> underflow=0; err_clr with
//    concurrent bad read -> underflow stays 1.
//  5 FWFT=1: write 0xA5 into empty -> next cycle rd_valid=1, rd_data=0xA5 without rd_en; FWFT=0:
//    same write, rd_en -> rd_data=0xA5, rd_valid=1 one cycle later.
//  6 Level 6, flush with wr_en=1 -> level=0, empty=1, overflow unchanged; next write 0x3C reads out
//    first.

Source files
------------

// File: rtl/amiq_fifo_prog.sv
// Single-clock FIFO, 2**P entries, programmable almost-full/almost-empty, sticky errors, flush.
// Latency: registered read gives data 1 cycle after pop; FWFT shows head word 1 cycle after write.
// Backpressure: writes are dropped while full and reads while empty, each setting a sticky error.
module amiq_fifo_prog #(
    parameter int DATA_W = 8,
    parameter int P      = 4,
    parameter bit FWFT   = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    input  logic [P-1:0]      alm_full_thresh,
    input  logic [P-1:0]      alm_empty_thresh,
    output logic              alm_full,
    output logic              alm_empty,
    output logic [P:0]        level,
    output logic              overflow,
    output logic              underflow,
    input  logic              err_clr
);
    localparam int         DEPTH   = 1 << P;
    localparam logic [P:0] DEPTH_L = (P+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [P-1:0]      wr_ptr;
    logic [P-1:0]      rd_ptr;
    logic              wr_acc;
    logic              rd_acc;
    logic [P:0]        level_nxt;
    logic [P:0]        free_nxt;

    // Flush swallows any concurrent request, so neither side is accepted nor flagged.
    assign wr_acc = wr_en && !full  && !flush;
    assign rd_acc = rd_en && !empty && !flush;

    always_comb begin
        level_nxt = level;
        if (flush) begin
            level_nxt = '0;
        end else begin
            case ({wr_acc, rd_acc})
                2'b10:   level_nxt = level + (P+1)'(1);
                2'b01:   level_nxt = level - (P+1)'(1);
                default: level_nxt = level;
            endcase
        end
    end

    assign free_nxt = DEPTH_L - level_nxt;

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            alm_full  <= 1'b0;
            alm_empty <= 1'b1;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_acc) wr_ptr <= wr_ptr + P'(1);
                if (rd_acc) rd_ptr <= rd_ptr + P'(1);
            end
            // All status flags derive from the same next level so they never disagree.
            level     <= level_nxt;
            full      <= (level_nxt == DEPTH_L);
            empty     <= (level_nxt == '0);
            alm_full  <= (free_nxt <= {1'b0, alm_full_thresh});
            alm_empty <= (level_nxt <= {1'b0, alm_empty_thresh});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (overflow  && !err_clr) || (wr_en && full  && !flush);
            underflow <= (underflow && !err_clr) || (rd_en && empty && !flush);
        end
    end

    generate
        if (FWFT) begin : g_fwft
            assign rd_valid = !empty;
            assign rd_data  = empty ? '0 : mem[rd_ptr];
        end else begin : g_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_valid <= 1'b0;
                    rd_data  <= '0;
                end else if (flush) begin
                    rd_valid <= 1'b0;
                end else begin
                    rd_valid <= rd_acc;
                    if (rd_acc) rd_data <= mem[rd_ptr];
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_amiq_fifo_prog.sv
// Directed bench: registered-read instance carries the main sequence, a FWFT instance covers fall-through.
module tb_amiq_fifo_prog;
    logic       clk = 1'b0;
    logic       rst_n, flush, wr_en, rd_en, err_clr;
    logic [7:0] wr_data;
    logic [3:0] alm_full_thresh, alm_empty_thresh;
    logic [7:0] rd_data;
    logic       rd_valid, full, empty, alm_full, alm_empty, overflow, underflow;
    logic [4:0] level;

    logic       f_wr_en, f_rd_en;
    logic [7:0] f_wr_data, f_rd_data;
    logic       f_rd_valid, f_full, f_empty, f_alm_full, f_alm_empty, f_overflow, f_underflow;
    logic [4:0] f_level;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    amiq_fifo_prog #(.DATA_W(8), .P(4), .FWFT(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
        .alm_full_thresh(alm_full_thresh), .alm_empty_thresh(alm_empty_thresh),
        .alm_full(alm_full), .alm_empty(alm_empty), .level(level),
        .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
    );

    amiq_fifo_prog #(.DATA_W(8), .P(4), .FWFT(1'b1)) dut_f (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(f_wr_en), .wr_data(f_wr_data),
        .rd_en(f_rd_en), .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
        .alm_full_thresh(alm_full_thresh), .alm_empty_thresh(alm_empty_thresh),
        .alm_full(f_alm_full), .alm_empty(f_alm_empty), .level(f_level),
        .overflow(f_overflow), .underflow(f_underflow), .err_clr(err_clr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
        wr_data = 8'h00; alm_full_thresh = 4'd3; alm_empty_thresh = 4'd2;
        f_wr_en = 1'b0; f_rd_en = 1'b0; f_wr_data = 8'h00;
        tick();
        chk("rst_level", level, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_alm_empty", alm_empty, 1);
        chk("rst_alm_full", alm_full, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_underflow", underflow, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // 1: asynchronous reset mid-cycle discards contents
        wr_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_data = 8'(i);
            tick();
        end
        wr_en = 1'b0;
        chk("t1_level5", level, 5);
        chk("t1_alm_empty0", alm_empty, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_async_level", level, 0);
        chk("t1_async_empty", empty, 1);
        chk("t1_async_alm_empty", alm_empty, 1);
        #2 rst_n = 1'b1;
        tick();

        // 2: fill to full with alm_full at 13, then overflow
        wr_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wr_data = 8'(i);
            tick();
            chk("t2_level", level, i + 1);
            chk("t2_alm_full", alm_full, (i + 1) >= 13);
            chk("t2_full", full, (i + 1) == 16);
        end
        chk("t2_no_ovf_yet", overflow, 0);
        wr_data = 8'h10;
        tick();
        chk("t2_overflow", overflow, 1);
        chk("t2_level_held", level, 16);

        // 3a: write+read at full -> only the read goes through
        rd_en = 1'b1;
        wr_data = 8'h11;
        tick();
        wr_en = 1'b0;
        chk("t3_full_wr_rd_level", level, 15);
        chk("t3_full_wr_rd_ovf", overflow, 1);
        chk("t3_first_word", rd_data, 8'h00);
        chk("t3_first_valid", rd_valid, 1);
        for (int i = 1; i < 16; i++) begin
            tick();
            chk("t2_readback", rd_data, i);
        end
        rd_en = 1'b0;
        chk("t2_drained_empty", empty, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t2_ovf_cleared", overflow, 0);

        // 3b: sustained simultaneous write+read at level 8
        wr_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr_data = 8'h20 + 8'(i);
            tick();
        end
        chk("t3_level8", level, 8);
        rd_en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            wr_data = 8'h28 + 8'(k);
            tick();
            chk("t3_stream_level", level, 8);
            chk("t3_stream_data", rd_data, 8'h20 + k);
        end
        wr_en = 1'b0;
        for (int j = 0; j < 8; j++) begin
            tick();
            chk("t3_drain_data", rd_data, 8'h34 + j);
            chk("t3_drain_alm_empty", alm_empty, (7 - j) <= 2);
        end
        rd_en = 1'b0;
        chk("t3_no_errors", {overflow, underflow}, 0);

        // 4: underflow and its clearing rules
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("t4_underflow", underflow, 1);
        chk("t4_rd_valid0", rd_valid, 0);
        tick();
        chk("t4_sticky", underflow, 1);
        err_clr = 1'b1;
        tick();
        chk("t4_cleared", underflow, 0);
        rd_en = 1'b1;
        tick();
        err_clr = 1'b0;
        rd_en = 1'b0;
        chk("t4_clr_vs_new", underflow, 1);

        // threshold extremes at level 0
        alm_full_thresh = 4'd15;
        alm_empty_thresh = 4'd0;
        tick();
        chk("thr_alm_full_lvl0", alm_full, 0);
        chk("thr_alm_empty_lvl0", alm_empty, 1);
        alm_full_thresh = 4'd3;
        alm_empty_thresh = 4'd2;

        // 5: registered read vs first-word-fall-through
        chk("t5_f_idle_valid", f_rd_valid, 0);
        wr_en = 1'b1; wr_data = 8'hA5;
        f_wr_en = 1'b1; f_wr_data = 8'hA5;
        tick();
        wr_en = 1'b0; f_wr_en = 1'b0;
        chk("t5_f_valid", f_rd_valid, 1);
        chk("t5_f_data", f_rd_data, 8'hA5);
        chk("t5_r_no_pop_valid", rd_valid, 0);
        rd_en = 1'b1; f_rd_en = 1'b1;
        tick();
        rd_en = 1'b0; f_rd_en = 1'b0;
        chk("t5_r_valid", rd_valid, 1);
        chk("t5_r_data", rd_data, 8'hA5);
        chk("t5_f_popped_valid", f_rd_valid, 0);
        chk("t5_f_empty", f_empty, 1);
        tick();
        chk("t5_r_valid_drop", rd_valid, 0);
        chk("t5_r_data_hold", rd_data, 8'hA5);

        // 6: flush at level 6 with concurrent requests
        wr_en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            wr_data = 8'h60 + 8'(i);
            tick();
        end
        wr_en = 1'b0;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("t6_level6", level, 6);
        chk("t6_pre_valid", rd_valid, 1);
        flush = 1'b1; wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hEE;
        tick();
        flush = 1'b0; rd_en = 1'b0;
        chk("t6_level0", level, 0);
        chk("t6_empty", empty, 1);
        chk("t6_alm_empty", alm_empty, 1);
        chk("t6_rd_valid", rd_valid, 0);
        chk("t6_ovf_kept", overflow, 0);
        chk("t6_udf_kept", underflow, 1);
        wr_data = 8'h3C;
        tick();
        wr_data = 8'h3D;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("t6_first_out", rd_data, 8'h3C);
        chk("t6_level_after", level, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
